// File: rtl/dsi_lanes_distributor_pkg.sv
// dsi_lanes_pkg: shared types and constants for the DSI lane distributor.
//   state_t     - distributor FSM states
//   lane_cnt_t  - active lane count minus one
//   BUF_BYTES   - byte capacity of the staging FIFO
//   strb_bytes  - number of valid bytes in a thermometer-coded strobe
package dsi_lanes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HS_RQST = 2'd1,
    SEND    = 2'd2,
    EOT     = 2'd3
  } state_t;

  typedef logic [1:0] lane_cnt_t;

  localparam int BUF_BYTES = 8;

  function automatic logic [2:0] strb_bytes(input logic [3:0] strb);
    return 3'(strb[0]) + 3'(strb[1]) + 3'(strb[2]) + 3'(strb[3]);
  endfunction

endpackage

// File: rtl/dsi_lanes_distributor_if.sv
// dsi_lanes_distributor_if: upstream word interface from the packet assembler.
//   iface_write_data  word, byte0 = [7:0] goes out first
//   iface_write_strb  thermometer byte strobe
//   iface_write_rqst  word valid
//   iface_last_word   last word of the burst (qualified by iface_write_rqst)
//   iface_data_rqst   distributor can accept a word this cycle
// Handshake: a word transfers on a rising clock edge where iface_write_rqst
// and iface_data_rqst are both high; iface_data_rqst never depends on
// iface_write_rqst.
interface dsi_lanes_distributor_if;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst;
  logic        iface_last_word;
  logic        iface_data_rqst;

  modport master (
    output iface_write_data, iface_write_strb, iface_write_rqst, iface_last_word,
    input  iface_data_rqst
  );

  modport slave (
    input  iface_write_data, iface_write_strb, iface_write_rqst, iface_last_word,
    output iface_data_rqst
  );
endinterface

// File: rtl/dsi_lanes_distributor_buffer.sv
// dsi_byte_buffer: 8-byte FIFO with 0..4 byte write and 0..4 byte read per
// cycle. The caller guarantees no overflow and no read beyond fill.
//   clk_sys, rst  clock, synchronous active-high reset (empties the FIFO)
//   i_wr_n        number of bytes written from i_wr_data (low bytes first)
//   i_wr_data     write word
//   i_rd_n        number of bytes popped from the head
//   o_fill        bytes currently stored (0..8)
//   o_head        head window: byte k = k-th oldest stored byte
module dsi_byte_buffer
  import dsi_lanes_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [2:0]  i_wr_n,
  input  logic [31:0] i_wr_data,
  input  logic [2:0]  i_rd_n,
  output logic [3:0]  o_fill,
  output logic [31:0] o_head
);

  logic [7:0] r_mem [BUF_BYTES];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_fill;

  // Storage carries no reset; pointers and fill define what is valid.
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < i_wr_n) r_mem[r_wr_ptr + 3'(i)] <= i_wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + i_wr_n;
      r_rd_ptr <= r_rd_ptr + i_rd_n;
      r_fill   <= r_fill + {1'b0, i_wr_n} - {1'b0, i_rd_n};
    end
  end

  always_comb begin
    o_head = '0;
    for (int k = 0; k < 4; k++) o_head[8*k +: 8] = r_mem[r_rd_ptr + 3'(k)];
  end

  assign o_fill = r_fill;

endmodule

// File: rtl/dsi_lanes_distributor.sv
// dsi_lanes_distributor: buffers the assembled DSI byte stream and spreads it
// round-robin over 1..4 D-PHY data lanes, one byte per lane per cycle,
// requesting HS mode for the duration of the burst.
//   clk_sys, rst    clock, synchronous active-high reset
//   iface           upstream word interface (slave side)
//   lanes_number    active lanes minus one, latched at burst start
//   hs_rqst/hs_ready HS request to / SoT-EoT status from the PHY
//   lane_data/lane_valid/lane_last  registered per-lane byte outputs
//   underflow_err   sticky: lanes starved mid-burst
//   tx_byte_count, burst_count  statistics
//   dbg_state       current FSM state
// Optional feature: define DSI_DISTRIB_STATS_EN to build the statistics
// counters; otherwise both statistics ports read 0.
module dsi_lanes_distributor
  import dsi_lanes_pkg::*;
#(
  parameter int LANES_MAX = 4
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  dsi_lanes_distributor_if.slave iface,
  input  lane_cnt_t              lanes_number,
  output logic                   hs_rqst,
  input  logic                   hs_ready,
  output logic [8*LANES_MAX-1:0] lane_data,
  output logic [LANES_MAX-1:0]   lane_valid,
  output logic [LANES_MAX-1:0]   lane_last,
  output logic                   underflow_err,
  output logic [31:0]            tx_byte_count,
  output logic [15:0]            burst_count,
  output state_t                 dbg_state
);

  state_t    r_state;
  lane_cnt_t r_n;
  logic      r_last_seen;
  logic      r_hs_rqst;
  logic      r_underflow;
  logic [8*LANES_MAX-1:0] r_lane_data;
  logic [LANES_MAX-1:0]   r_lane_valid;
  logic [LANES_MAX-1:0]   r_lane_last;

  logic        w_accept;
  logic [2:0]  w_wr_n;
  logic [2:0]  w_rd_n;
  logic [2:0]  w_n;
  logic [3:0]  w_fill;
  logic [31:0] w_head;
  logic        w_can_read;
  logic        w_underrun;
  logic        w_drain;

  assign w_accept = iface.iface_write_rqst & iface.iface_data_rqst;
  assign w_wr_n   = w_accept ? strb_bytes(iface.iface_write_strb) : 3'd0;
  assign w_n      = {1'b0, r_n} + 3'd1;

  // Once the last word is in, partial groups are flushed; before that a
  // partial group means the upstream is late and the lanes starve.
  assign w_can_read = (r_state == SEND) && ((w_fill >= {1'b0, w_n}) || r_last_seen);
  assign w_underrun = (r_state == SEND) && (w_fill < {1'b0, w_n}) && !r_last_seen;
  assign w_rd_n     = !w_can_read ? 3'd0 :
                      (w_fill < {1'b0, w_n}) ? w_fill[2:0] : w_n;
  // No writes happen after last_seen, so fill == rd_bytes empties the buffer.
  assign w_drain    = w_can_read && r_last_seen && (w_fill == {1'b0, w_rd_n});

  // The fill <= 4 gate keeps fill + 4 within the 8-byte buffer.
  always_comb begin
    iface.iface_data_rqst = 1'b0;
    case (r_state)
      IDLE:          iface.iface_data_rqst = 1'b1;
      HS_RQST, SEND: iface.iface_data_rqst = (w_fill <= 4'd4) && !r_last_seen;
      default:       iface.iface_data_rqst = 1'b0;
    endcase
  end

  dsi_byte_buffer u_buf (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .i_wr_n    (w_wr_n),
    .i_wr_data (iface.iface_write_data),
    .i_rd_n    (w_rd_n),
    .o_fill    (w_fill),
    .o_head    (w_head)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_last_seen  <= 1'b0;
      r_hs_rqst    <= 1'b0;
      r_underflow  <= 1'b0;
      r_lane_data  <= '0;
      r_lane_valid <= '0;
      r_lane_last  <= '0;
    end else begin
      r_lane_data  <= '0;
      r_lane_valid <= '0;
      r_lane_last  <= '0;
      if (w_accept && iface.iface_last_word) r_last_seen <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_n       <= lanes_number;
            r_hs_rqst <= 1'b1;
            r_state   <= HS_RQST;
          end
        end
        HS_RQST: begin
          if (hs_ready) r_state <= SEND;
        end
        SEND: begin
          if (w_underrun) r_underflow <= 1'b1;
          for (int k = 0; k < LANES_MAX; k++) begin
            if (3'(k) < w_rd_n) begin
              r_lane_valid[k]       <= 1'b1;
              r_lane_last[k]        <= w_drain;
              r_lane_data[8*k +: 8] <= w_head[8*k +: 8];
            end
          end
          if (w_drain) begin
            r_hs_rqst <= 1'b0;
            r_state   <= EOT;
          end
        end
        EOT: begin
          if (!hs_ready) begin
            r_last_seen <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hs_rqst       = r_hs_rqst;
  assign lane_data     = r_lane_data;
  assign lane_valid    = r_lane_valid;
  assign lane_last     = r_lane_last;
  assign underflow_err = r_underflow;
  assign dbg_state     = r_state;

`ifdef DSI_DISTRIB_STATS_EN
  logic [31:0] r_tx_bytes;
  logic [15:0] r_bursts;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_tx_bytes <= '0;
      r_bursts   <= '0;
    end else begin
      r_tx_bytes <= r_tx_bytes + 32'(w_rd_n);
      if (w_drain) r_bursts <= r_bursts + 16'd1;
    end
  end

  assign tx_byte_count = r_tx_bytes;
  assign burst_count   = r_bursts;
`else
  assign tx_byte_count = '0;
  assign burst_count   = '0;
`endif

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Self-checking bench for dsi_lanes_distributor. Expected lane cycles are
// derived from the bytes driven and the active lane count, queued when each
// word is accepted, and popped when the DUT shows valid lane bytes.
module tb_dsi_lanes_distributor;
  import dsi_lanes_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst;
  lane_cnt_t   lanes_number;
  logic        hs_rqst;
  logic        hs_ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [3:0]  lane_last;
  logic        underflow_err;
  logic [31:0] tx_byte_count;
  logic [15:0] burst_count;
  state_t      dbg_state;

  dsi_lanes_distributor_if bus ();

  dsi_lanes_distributor #(.LANES_MAX(4)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .iface         (bus.slave),
    .lanes_number  (lanes_number),
    .hs_rqst       (hs_rqst),
    .hs_ready      (hs_ready),
    .lane_data     (lane_data),
    .lane_valid    (lane_valid),
    .lane_last     (lane_last),
    .underflow_err (underflow_err),
    .tx_byte_count (tx_byte_count),
    .burst_count   (burst_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];       // {lane_data, lane_valid, lane_last}
  logic [7:0]  model_bytes[$];
  int          model_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_chunk(input int cnt, input bit is_last);
    logic [31:0] d;
    logic [3:0]  v;
    logic [3:0]  l;
    d = '0; v = '0; l = '0;
    for (int k = 0; k < cnt; k++) begin
      d[8*k +: 8] = model_bytes.pop_front();
      v[k] = 1'b1;
      l[k] = is_last;
    end
    exp_q.push_back({d, v, l});
  endtask

  always @(negedge clk_sys) begin
    logic [31:0] mask;
    logic [39:0] exp_v;
    if (lane_valid !== 4'b0000) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL lane_unexpected observed=%h_%b_%b expected=none", lane_data, lane_valid, lane_last);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        mask = '0;
        for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{lane_valid[k]}};
        n_cmp++;
        assert ({lane_data & mask, lane_valid, lane_last} === exp_v) else begin
          n_fail++;
          $error("FAIL lane_cycle observed=%h_%b_%b expected=%h_%b_%b",
                 lane_data & mask, lane_valid, lane_last, exp_v[39:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input bit last);
    int t;
    t = 0;
    @(negedge clk_sys);
    bus.iface_write_data = d;
    bus.iface_write_strb = s;
    bus.iface_last_word  = last;
    bus.iface_write_rqst = 1'b1;
    while (bus.iface_data_rqst !== 1'b1 && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    chk("send_timeout", 32'(t < 200), 32'd1);
    @(posedge clk_sys);
    #1;
    bus.iface_write_rqst = 1'b0;
    bus.iface_last_word  = 1'b0;
    for (int k = 0; k < 4; k++) if (s[k]) model_bytes.push_back(d[8*k +: 8]);
    if (last) begin
      while (model_bytes.size() > model_n) push_chunk(model_n, 1'b0);
      if (model_bytes.size() > 0) push_chunk(model_bytes.size(), 1'b1);
    end else begin
      while (model_bytes.size() >= model_n) push_chunk(model_n, 1'b0);
    end
  endtask

  // PHY stand-in: SoT after `delay` cycles, EoT two cycles after release.
  task automatic phy_session(input int delay);
    int t;
    t = 0;
    while (hs_rqst !== 1'b1 && t < 100) begin @(negedge clk_sys); t++; end
    chk("hs_rqst_rise_timeout", 32'(t < 100), 32'd1);
    repeat (delay) @(negedge clk_sys);
    hs_ready = 1'b1;
    t = 0;
    while (hs_rqst !== 1'b0 && t < 300) begin @(negedge clk_sys); t++; end
    chk("hs_rqst_fall_timeout", 32'(t < 300), 32'd1);
    chk("eot_state", 32'(dbg_state), 32'(EOT));
    repeat (2) @(negedge clk_sys);
    hs_ready = 1'b0;
    t = 0;
    while (dbg_state !== IDLE && t < 20) begin @(negedge clk_sys); t++; end
    chk("idle_after_eot", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hs_ready = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    exp_q.delete();
    model_bytes.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.iface_write_data = '0;
    bus.iface_write_strb = '0;
    bus.iface_write_rqst = 1'b0;
    bus.iface_last_word  = 1'b0;
    lanes_number = 2'd3;
    hs_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_data_rqst", 32'(bus.iface_data_rqst), 32'd1);
    chk("rst_hs_rqst", 32'(hs_rqst), 32'd0);
    chk("rst_lane_data", lane_data, 32'd0);
    chk("rst_lane_valid", 32'(lane_valid), 32'd0);
    chk("rst_lane_last", 32'(lane_last), 32'd0);
    chk("rst_underflow", 32'(underflow_err), 32'd0);
    chk("rst_tx_bytes", tx_byte_count, 32'd0);
    chk("rst_bursts", 32'(burst_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // 4 lanes, two full words, SoT after 3 cycles
    lanes_number = 2'd3; model_n = 4;
    fork
      begin
        send_word(32'h03020100, 4'b1111, 1'b0);
        send_word(32'h07060504, 4'b1111, 1'b1);
      end
      phy_session(3);
    join
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 1 lane, three bytes in one last word
    lanes_number = 2'd0; model_n = 1;
    fork
      send_word(32'h00CCBBAA, 4'b0111, 1'b1);
      phy_session(2);
    join
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3 lanes, 7 bytes; lanes_number changes mid-burst must be ignored
    lanes_number = 2'd2; model_n = 3;
    fork
      begin
        send_word(32'h13121110, 4'b1111, 1'b0);
        lanes_number = 2'd0;
        send_word(32'h00161514, 4'b0111, 1'b1);
      end
      phy_session(2);
    join
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_no_underflow", 32'(underflow_err), 32'd0);

    // 2 lanes, upstream stall with one byte buffered
    lanes_number = 2'd1; model_n = 2;
    fork
      begin
        send_word(32'h000000A1, 4'b0001, 1'b0);
        repeat (6) @(negedge clk_sys);
        chk("t4_underflow_set", 32'(underflow_err), 32'd1);
        chk("t4_lanes_idle", 32'(lane_valid), 32'd0);
        chk("t4_in_send", 32'(dbg_state), 32'(SEND));
        send_word(32'h00A4A3A2, 4'b0111, 1'b1);
      end
      phy_session(1);
    join
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_underflow_sticky", 32'(underflow_err), 32'd1);

    // reset while in SEND with 6 bytes buffered
    lanes_number = 2'd3; model_n = 4;
    send_word(32'h23222120, 4'b1111, 1'b0);
    send_word(32'h00002524, 4'b0011, 1'b0);
    chk("t5_gate_closed", 32'(bus.iface_data_rqst), 32'd0);
    @(negedge clk_sys);
    hs_ready = 1'b1;
    @(negedge clk_sys);
    chk("t5_in_send", 32'(dbg_state), 32'(SEND));
    rst = 1'b1;
    hs_ready = 1'b0;
    @(negedge clk_sys);
    chk("t5_hs_rqst", 32'(hs_rqst), 32'd0);
    chk("t5_lane_valid", 32'(lane_valid), 32'd0);
    chk("t5_lane_data", lane_data, 32'd0);
    chk("t5_data_rqst", 32'(bus.iface_data_rqst), 32'd1);
    chk("t5_state", 32'(dbg_state), 32'(IDLE));
    chk("t5_underflow_cleared", 32'(underflow_err), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_bytes.delete();
    lanes_number = 2'd1; model_n = 2;
    fork
      send_word(32'hDDCCBBAA, 4'b1111, 1'b1);
      phy_session(2);
    join
    chk("t5_after_drained", 32'(exp_q.size()), 32'd0);

    // statistics: bursts of 8 and 5 bytes from a clean reset
    do_reset();
    lanes_number = 2'd3; model_n = 4;
    fork
      begin
        send_word(32'h33323130, 4'b1111, 1'b0);
        send_word(32'h37363534, 4'b1111, 1'b1);
      end
      phy_session(2);
    join
    lanes_number = 2'd0; model_n = 1;
    fork
      begin
        send_word(32'h43424140, 4'b1111, 1'b0);
        send_word(32'h00000044, 4'b0001, 1'b1);
      end
      phy_session(2);
    join
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
`ifdef DSI_DISTRIB_STATS_EN
    chk("t6_tx_bytes", tx_byte_count, 32'd13);
    chk("t6_bursts", 32'(burst_count), 32'd2);
`else
    chk("t6_tx_bytes", tx_byte_count, 32'd0);
    chk("t6_bursts", 32'(burst_count), 32'd0);
`endif

    repeat (3) @(negedge clk_sys);
    chk("final_idle_hs", 32'(hs_rqst), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
